noc_turn_scheduler: RTL and testbench
=====================================

// Module: noc_turn_scheduler
// PURPOSE
//  Per-router scheduler feeding the route logic. Owns the 5-bit one-hot turn vector of each
//  output port (N,S,E,W,L) and rotates it round-robin among the inputs requesting that port.
//  Tracks downstream buffer credits per output and drives the *_port_full flags.
//  Sits beside the routing logic in each router tile; consumes its *_port_enable grants.
// PARAMETERS
//  BUF_DEPTH  4                          downstream FIFO slots per output = initial credits
//  CNT_W      $clog2(BUF_DEPTH+1)        credit counter width (derived, do not override)
// PORTS
//  clk               in   1   router clock
//  rst               in   1   synchronous reset, active-high
//  N_req_i..L_req_i  in   5   per-input one-hot requested output {N,S,E,W,L}; 0 = none
//  N_port_enable..L_port_enable  in  1  transfer into output port this cycle (from route logic)
//  N_credit_ret..L_credit_ret    in  1  downstream freed one slot of that output
//  N_turn..L_turn    out  5   one-hot input owning the output: N=10000 S=01000 E=00100 W=00010 L=00001
//  N_port_full..L_port_full      out 1  output has zero credits
//  credit_err        out  1   sticky: credit overflow or enable-while-full seen
// BEHAVIOUR
//  - Reset: N/S/E/W_turn=5'b00001 (L), L_turn=5'b10000 (N); all credit counters=BUF_DEPTH;
//    all *_port_full=0; credit_err=0. rst mid-operation wins over all updates same edge.
//  - All outputs registered; changes visible the cycle after the causing event.
//  - Round-robin order N->S->E->W->L->N. Same-port input is never eligible (no U-turn):
//    bit for input X is masked when scheduling output X; turn never equals that bit.
//  - Advance per output o, at each edge: trigger = o_port_enable OR holder not requesting o.
//    On trigger, search inputs after holder in RR order (wrapping, holder checked last) for
//    the first eligible input with req[o]=1; turn <= that input. None found: hold turn.
//    No trigger: hold (holder keeps ownership while blocked by port_full).
//  - Holder that transfers and is sole requester keeps the turn (search wraps onto it).
//  - Credits per output: enable only -> cnt-1; ret only -> cnt+1; both -> unchanged.
//    port_full = (cnt_next == 0), registered.
//  - Boundary: enable while cnt==0 -> cnt stays 0, credit_err<=1. ret while cnt==BUF_DEPTH
//    -> cnt saturates, credit_err<=1. credit_err clears only on rst.
//  - req_i with >1 bit set: illegal; treat as 0 (no request) and set credit_err.
//  - Five outputs are independent; simultaneous events on all ports handled same cycle.
// STRUCTURE
//  - noc_pkg: port index enum (P_N=4..P_L=0), one-hot TURN_N/S/E/W/L constants,
//    rr_next(turn,mask) function.
//  - Sub-module noc_rr_turn: one output's turn register + credit counter; params
//    SELF_BIT, RESET_TURN, BUF_DEPTH. Instantiated 5x; top does req transposition + err OR.
// TESTING
//  1 Reset: rst=1 two cycles -> N_turn=00001, L_turn=10000, all full=0, credit_err=0.
//  2 RR fairness: N,E,L all req S, S_port_enable each cycle -> S_turn cycles
//    10000,00100,00001,10000 on consecutive cycles.
//  3 Idle skip: S_turn=00001, only W_req_i=01000 (S) -> next cycle S_turn=00010; hold after.
//  4 Credits: BUF_DEPTH=4, 4 E_port_enable no ret -> E_port_full=1 after 4th; one
//    E_credit_ret -> E_port_full=0 next cycle; enable+ret same cycle -> count unchanged.
//  5 Errors: E_port_enable while full -> credit_err=1, count stays 0; ret at 4 -> err, sat.
//  6 U-turn mask + mid-op reset: N_req_i=10000 -> N_turn never 10000; rst mid-burst ->
//    reset values next cycle.

Source files
------------

// File: rtl/noc_turn_scheduler_pkg.sv
// Shared definitions for the NoC turn scheduler.
// Contents:
//   port_e      port index, N=4 .. L=0 (bit position in every 5-bit vector)
//   TURN_*      one-hot turn encodings
//   rr_next()   round-robin successor of a one-hot turn among a request mask
package noc_turn_scheduler_pkg;

    typedef enum logic [2:0] {
        P_L = 3'd0,
        P_W = 3'd1,
        P_E = 3'd2,
        P_S = 3'd3,
        P_N = 3'd4
    } port_e;

    localparam int NUM_PORTS = 5;

    localparam logic [4:0] TURN_N = 5'b10000;
    localparam logic [4:0] TURN_S = 5'b01000;
    localparam logic [4:0] TURN_E = 5'b00100;
    localparam logic [4:0] TURN_W = 5'b00010;
    localparam logic [4:0] TURN_L = 5'b00001;

    // RR order N->S->E->W->L->N is descending bit index with wrap 0->4.
    // The holder itself is examined last, so a sole requester keeps the turn.
    // An empty mask returns the current turn unchanged.
    function automatic logic [4:0] rr_next(input logic [4:0] turn, input logic [4:0] mask);
        logic [4:0] res;
        logic [2:0] h;
        logic [2:0] idx;
        logic       found;
        res   = turn;
        h     = 3'd0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (turn[i]) h = 3'(i);
        end
        idx = h;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (idx == 3'd0) ? 3'd4 : idx - 3'd1;
            if (!found && mask[idx]) begin
                res   = 5'b00001 << idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/noc_turn_scheduler_if.sv
// Bundle between the route logic (master) and the turn scheduler (slave).
// Per port X in {N,S,E,W,L}:
//   X_req_i         5  one-hot output requested by input X, 0 = none
//   X_port_enable   1  transfer into output X this cycle
//   X_credit_ret    1  downstream of output X freed one slot
//   X_turn          5  one-hot input owning output X
//   X_port_full     1  output X has no credits
// credit_err         1  sticky credit / request error
interface noc_turn_scheduler_if;
    logic [4:0] N_req_i, S_req_i, E_req_i, W_req_i, L_req_i;
    logic       N_port_enable, S_port_enable, E_port_enable, W_port_enable, L_port_enable;
    logic       N_credit_ret, S_credit_ret, E_credit_ret, W_credit_ret, L_credit_ret;
    logic [4:0] N_turn, S_turn, E_turn, W_turn, L_turn;
    logic       N_port_full, S_port_full, E_port_full, W_port_full, L_port_full;
    logic       credit_err;

    modport master (
        output N_req_i, S_req_i, E_req_i, W_req_i, L_req_i,
        output N_port_enable, S_port_enable, E_port_enable, W_port_enable, L_port_enable,
        output N_credit_ret, S_credit_ret, E_credit_ret, W_credit_ret, L_credit_ret,
        input  N_turn, S_turn, E_turn, W_turn, L_turn,
        input  N_port_full, S_port_full, E_port_full, W_port_full, L_port_full,
        input  credit_err
    );

    modport slave (
        input  N_req_i, S_req_i, E_req_i, W_req_i, L_req_i,
        input  N_port_enable, S_port_enable, E_port_enable, W_port_enable, L_port_enable,
        input  N_credit_ret, S_credit_ret, E_credit_ret, W_credit_ret, L_credit_ret,
        output N_turn, S_turn, E_turn, W_turn, L_turn,
        output N_port_full, S_port_full, E_port_full, W_port_full, L_port_full,
        output credit_err
    );
endinterface

// File: rtl/noc_turn_scheduler_rr_turn.sv
// One output port: round-robin turn register plus downstream credit counter.
// Ports:
//   clk, rst   router clock, synchronous active-high reset
//   req_i      bit i = input i requests this output (already validity-filtered)
//   enable_i   transfer into this output this cycle
//   ret_i      downstream freed one slot
//   turn_o     registered one-hot owner
//   full_o     registered, credit count is zero
//   err_o      combinational pulse: underflow or overflow attempt this cycle
module noc_turn_scheduler_rr_turn
    import noc_turn_scheduler_pkg::*;
#(
    parameter int         SELF_BIT   = 0,
    parameter logic [4:0] RESET_TURN = TURN_N,
    parameter int         BUF_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req_i,
    input  logic       enable_i,
    input  logic       ret_i,
    output logic [4:0] turn_o,
    output logic       full_o,
    output logic       err_o
);
    localparam int             CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam logic [4:0]     SELF_MASK = 5'(1 << SELF_BIT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    logic [4:0]       turn_q, turn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q;
    logic [4:0]       mask;
    logic             trigger;

    always_comb begin
        // No U-turn: the input sharing this port's index is never eligible.
        mask    = req_i & ~SELF_MASK;
        // Re-arbitrate on a transfer or when the holder has dropped its request;
        // a blocked holder keeps ownership.
        trigger = enable_i | ~(|(mask & turn_q));
        turn_d  = trigger ? rr_next(turn_q, mask) : turn_q;

        cnt_d = cnt_q;
        err_o = 1'b0;
        if (enable_i && !ret_i) begin
            if (cnt_q == '0) err_o = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end else if (ret_i && !enable_i) begin
            if (cnt_q == FULL_CNT) err_o = 1'b1;
            else                   cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            turn_q <= RESET_TURN;
            cnt_q  <= FULL_CNT;
            full_q <= 1'b0;
        end else begin
            turn_q <= turn_d;
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == '0);
        end
    end

    assign turn_o = turn_q;
    assign full_o = full_q;
endmodule

// File: rtl/noc_turn_scheduler.sv
// Per-router turn scheduler: five independent output arbiters with credit tracking.
// Ports:
//   clk   router clock
//   rst   synchronous active-high reset
//   bus   noc_turn_scheduler_if.slave (requests, enables, credit returns in;
//         turns, full flags, sticky credit_err out)
module noc_turn_scheduler
    import noc_turn_scheduler_pkg::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_turn_scheduler_if.slave  bus
);
    // Packed per-input/per-output vectors, index = port bit (N=4 .. L=0).
    logic [4:0][4:0] req_raw;
    logic [4:0][4:0] req_eff;
    logic [4:0][4:0] req_col;
    logic [4:0]      legal;
    logic [4:0]      enable_v, ret_v;
    logic [4:0]      turn_v [NUM_PORTS];
    logic            full_v [NUM_PORTS];
    logic            err_v  [NUM_PORTS];
    logic            any_err;
    logic            err_q;

    assign req_raw  = {bus.N_req_i, bus.S_req_i, bus.E_req_i, bus.W_req_i, bus.L_req_i};
    assign enable_v = {bus.N_port_enable, bus.S_port_enable, bus.E_port_enable,
                       bus.W_port_enable, bus.L_port_enable};
    assign ret_v    = {bus.N_credit_ret, bus.S_credit_ret, bus.E_credit_ret,
                       bus.W_credit_ret, bus.L_credit_ret};

    // Multi-hot requests are dropped and flagged; then transpose so each
    // output sees a column of which inputs want it.
    always_comb begin
        legal   = '0;
        req_eff = '0;
        req_col = '0;
        any_err = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            legal[i]   = ((req_raw[i] & (req_raw[i] - 5'd1)) == 5'd0);
            req_eff[i] = legal[i] ? req_raw[i] : 5'd0;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_col[o][i] = req_eff[i][o];
            end
            any_err = any_err | err_v[o];
        end
        any_err = any_err | ~(&legal);
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        noc_turn_scheduler_rr_turn #(
            .SELF_BIT   (o),
            .RESET_TURN ((o == int'(P_L)) ? TURN_N : TURN_L),
            .BUF_DEPTH  (BUF_DEPTH)
        ) u_rr (
            .clk      (clk),
            .rst      (rst),
            .req_i    (req_col[o]),
            .enable_i (enable_v[o]),
            .ret_i    (ret_v[o]),
            .turn_o   (turn_v[o]),
            .full_o   (full_v[o]),
            .err_o    (err_v[o])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | any_err;
    end

    assign bus.N_turn      = turn_v[4];
    assign bus.S_turn      = turn_v[3];
    assign bus.E_turn      = turn_v[2];
    assign bus.W_turn      = turn_v[1];
    assign bus.L_turn      = turn_v[0];
    assign bus.N_port_full = full_v[4];
    assign bus.S_port_full = full_v[3];
    assign bus.E_port_full = full_v[2];
    assign bus.W_port_full = full_v[1];
    assign bus.L_port_full = full_v[0];
    assign bus.credit_err  = err_q;
endmodule

// File: tb/tb_noc_turn_scheduler.sv
module tb_noc_turn_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    noc_turn_scheduler_if bus ();

    noc_turn_scheduler #(.BUF_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // kind: 0..4 = N,S,E,W,L turn; 5..9 = N,S,E,W,L full; 10 = credit_err
    typedef struct {
        int         kind;
        logic [4:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    localparam int K_NT = 0, K_ST = 1, K_ET = 2, K_WT = 3, K_LT = 4;
    localparam int K_NF = 5, K_SF = 6, K_EF = 7, K_WF = 8, K_LF = 9, K_ERR = 10;

    function automatic logic [4:0] observe(input int kind);
        case (kind)
            K_NT:    return bus.N_turn;
            K_ST:    return bus.S_turn;
            K_ET:    return bus.E_turn;
            K_WT:    return bus.W_turn;
            K_LT:    return bus.L_turn;
            K_NF:    return {4'd0, bus.N_port_full};
            K_SF:    return {4'd0, bus.S_port_full};
            K_EF:    return {4'd0, bus.E_port_full};
            K_WF:    return {4'd0, bus.W_port_full};
            K_LF:    return {4'd0, bus.L_port_full};
            default: return {4'd0, bus.credit_err};
        endcase
    endfunction

    task automatic expect_next(input int kind, input logic [4:0] val, input string tag);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Clock the DUT once, then compare every expectation queued for this edge.
    task automatic step();
        exp_t       e;
        logic [4:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            n_total++;
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
        end
    endtask

    task automatic clear_inputs();
        bus.N_req_i = 5'd0; bus.S_req_i = 5'd0; bus.E_req_i = 5'd0;
        bus.W_req_i = 5'd0; bus.L_req_i = 5'd0;
        bus.N_port_enable = 1'b0; bus.S_port_enable = 1'b0; bus.E_port_enable = 1'b0;
        bus.W_port_enable = 1'b0; bus.L_port_enable = 1'b0;
        bus.N_credit_ret = 1'b0; bus.S_credit_ret = 1'b0; bus.E_credit_ret = 1'b0;
        bus.W_credit_ret = 1'b0; bus.L_credit_ret = 1'b0;
    endtask

    task automatic expect_reset_state(input string tag);
        expect_next(K_NT, 5'b00001, {tag, "_N_turn"});
        expect_next(K_ST, 5'b00001, {tag, "_S_turn"});
        expect_next(K_ET, 5'b00001, {tag, "_E_turn"});
        expect_next(K_WT, 5'b00001, {tag, "_W_turn"});
        expect_next(K_LT, 5'b10000, {tag, "_L_turn"});
        for (int k = K_NF; k <= K_LF; k++) expect_next(k, 5'd0, {tag, "_full"});
        expect_next(K_ERR, 5'd0, {tag, "_err"});
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        expect_reset_state(tag);
        step();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();

        // 1 reset held two cycles
        rst = 1'b1;
        step();
        expect_reset_state("reset");
        step();
        rst = 1'b0;

        // 2 RR fairness on output S among N, E, L
        bus.N_req_i = 5'b01000; bus.E_req_i = 5'b01000; bus.L_req_i = 5'b01000;
        bus.S_port_enable = 1'b1;
        expect_next(K_ST, 5'b10000, "rr_1"); step();
        expect_next(K_ST, 5'b00100, "rr_2"); step();
        expect_next(K_ST, 5'b00001, "rr_3"); step();
        expect_next(K_ST, 5'b10000, "rr_4");
        expect_next(K_SF, 5'd1, "rr_S_full_after_4");
        expect_next(K_ERR, 5'd0, "rr_no_err"); step();
        clear_inputs();
        do_reset("reset2");

        // 3 idle skip to W, hold, sole requester keeps turn on transfer
        bus.W_req_i = 5'b01000;
        expect_next(K_ST, 5'b00010, "skip_to_W");
        expect_next(K_NT, 5'b00001, "skip_N_untouched"); step();
        expect_next(K_ST, 5'b00010, "skip_hold"); step();
        bus.S_port_enable = 1'b1;
        expect_next(K_ST, 5'b00010, "sole_keeps"); step();
        clear_inputs();

        // 4 credits on E
        bus.E_port_enable = 1'b1;
        expect_next(K_EF, 5'd0, "cred_e1"); step();
        expect_next(K_EF, 5'd0, "cred_e2"); step();
        expect_next(K_EF, 5'd0, "cred_e3"); step();
        expect_next(K_EF, 5'd1, "cred_e4_full"); step();
        bus.E_port_enable = 1'b0; bus.E_credit_ret = 1'b1;
        expect_next(K_EF, 5'd0, "cred_ret_unfull"); step();
        bus.E_port_enable = 1'b1;
        expect_next(K_EF, 5'd0, "cred_both"); step();
        bus.E_credit_ret = 1'b0;
        expect_next(K_EF, 5'd1, "cred_both_kept_1");
        expect_next(K_ERR, 5'd0, "cred_no_err"); step();

        // 5 underflow, overflow, illegal request
        expect_next(K_EF, 5'd1, "under_full");
        expect_next(K_ERR, 5'd1, "under_err"); step();
        bus.E_port_enable = 1'b0; bus.E_credit_ret = 1'b1;
        expect_next(K_EF, 5'd0, "under_stayed_0"); step();
        clear_inputs();
        do_reset("reset3");
        bus.W_credit_ret = 1'b1;
        expect_next(K_ERR, 5'd1, "over_err");
        expect_next(K_WF, 5'd0, "over_W_full"); step();
        bus.W_credit_ret = 1'b0; bus.W_port_enable = 1'b1;
        expect_next(K_WF, 5'd0, "sat_w1"); step();
        expect_next(K_WF, 5'd0, "sat_w2"); step();
        expect_next(K_WF, 5'd0, "sat_w3"); step();
        expect_next(K_WF, 5'd1, "sat_w4_full");
        expect_next(K_ERR, 5'd1, "err_sticky"); step();
        clear_inputs();
        do_reset("reset4");
        bus.N_req_i = 5'b01100;
        expect_next(K_ERR, 5'd1, "illegal_err");
        expect_next(K_ST, 5'b00001, "illegal_S_ignored");
        expect_next(K_ET, 5'b00001, "illegal_E_ignored"); step();
        clear_inputs();
        do_reset("reset5");

        // 6 U-turn mask and mid-burst reset on output N
        bus.N_req_i = 5'b10000; bus.S_req_i = 5'b10000; bus.E_req_i = 5'b10000;
        bus.N_port_enable = 1'b1;
        expect_next(K_NT, 5'b01000, "uturn_1"); step();
        expect_next(K_NT, 5'b00100, "uturn_2"); step();
        expect_next(K_NT, 5'b01000, "uturn_3"); step();
        rst = 1'b1;
        expect_next(K_NT, 5'b00001, "midrst_N_turn");
        expect_next(K_NF, 5'd0, "midrst_N_full");
        expect_next(K_ERR, 5'd0, "midrst_err"); step();
        rst = 1'b0;
        expect_next(K_NT, 5'b01000, "post_rst_N_turn"); step();
        clear_inputs();
        bus.N_req_i = 5'b10000; bus.S_req_i = 5'd0; bus.E_req_i = 5'd0;
        expect_next(K_NT, 5'b01000, "uturn_only_self"); step();
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
